// File: rtl/move_pkg.sv
// move_pkg: shared definitions for the move_core transport-triggered CPU.
//   Address map constants for the S/D fields, bit positions of the
//   instruction fields, the control state encoding and small decode helpers.
//   Ports: none (package).
//   Optional feature: MOVE_CORE_SKIP_EN (skip_taken is only used when defined).
package move_pkg;

  // Address map shared by the source and destination fields.
  localparam logic [6:0] REG_BASE  = 7'h00;
  localparam logic [6:0] PC_ADDR   = 7'h20;
  localparam logic [6:0] SKIP_ADDR = 7'h21;
  localparam logic [6:0] HALT_ADDR = 7'h22;
  localparam logic [6:0] PIN_BASE  = 7'h40;

  // Instruction field bit positions.
  localparam int S_LSB  = 0;
  localparam int S_MSB  = 6;
  localparam int I0_BIT = 7;
  localparam int D_LSB  = 8;
  localparam int D_MSB  = 14;
  localparam int I1_BIT = 15;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // True when addr selects pin channel ch (0x40..0x4F window).
  function automatic logic pin_match(input logic [6:0] addr, input int ch);
    return (addr[6:4] == PIN_BASE[6:4]) && (addr[3:0] == 4'(ch));
  endfunction

  // A skip only happens when the value moved into the skip port is zero.
  function automatic logic skip_taken(input logic [6:0] addr, input logic value_is_zero);
    return (addr == SKIP_ADDR) && value_is_zero;
  endfunction

endpackage

// File: rtl/move_regfile.sv
// move_regfile: NREGS x WIDTH data register file for move_core.
//   clk, rst          : clock, asynchronous active-high reset (clears all regs)
//   rd_addr / rd_data : asynchronous read port (returns pre-write value)
//   wr_en / wr_addr / wr_data : synchronous write port
//   The caller guarantees addresses are below NREGS.
module move_regfile #(
  parameter int WIDTH = 16,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  assign rd_data = regs_q[rd_addr];

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/move_core.sv
// move_core: single-instruction (move) CPU with data registers, PC, skip,
//   halt and streaming pin channels mapped into one 7-bit address space.
//   clk, rst        : clock, asynchronous active-high reset
//   pc              : current instruction address
//   instruction     : {i1, D[6:0], i0, S[6:0]} for the instruction at pc
//   pin_in*         : per-channel input streams (valid/ready)
//   pin_out*        : per-channel output streams (valid/ready)
//   halted          : high while in HALT
//   Optional feature: define MOVE_CORE_SKIP_EN to make a zero written to
//   address 0x21 skip the next instruction; otherwise 0x21 is unmapped.
module move_core
  import move_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 32,
  parameter int NPINS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [WIDTH-1:0]       pc,
  input  logic [15:0]            instruction,
  input  logic [NPINS*WIDTH-1:0] pin_in,
  input  logic [NPINS-1:0]       pin_in_valid,
  output logic [NPINS-1:0]       pin_in_ready,
  output logic [NPINS*WIDTH-1:0] pin_out,
  output logic [NPINS-1:0]       pin_out_valid,
  input  logic [NPINS-1:0]       pin_out_ready,
  output logic                   halted
);

  logic [6:0] s, d;
  logic       i0, i1;

  state_e                   state_q, state_d;
  logic [WIDTH-1:0]         pc_q, pc_d;
  logic [NPINS*WIDTH-1:0]   pin_out_q, pin_out_d;
  logic [NPINS-1:0]         pin_out_valid_q, pin_out_valid_d;

  logic                     s_is_reg, d_is_reg;
  logic [NPINS-1:0]         s_pin, d_pin;
  logic [WIDTH-1:0]         rf_rd_data, rd_val, src_val, wr_val;
  logic                     stall, exec;

  assign s  = instruction[S_MSB:S_LSB];
  assign i0 = instruction[I0_BIT];
  assign d  = instruction[D_MSB:D_LSB];
  assign i1 = instruction[I1_BIT];

  // Source read, write value and stall detection. s_pin only flags a real
  // pin read (i0=0), so immediates aimed at a pin address never consume.
  always_comb begin
    s_is_reg = int'(s - REG_BASE) < NREGS;
    d_is_reg = int'(d - REG_BASE) < NREGS;
    s_pin    = '0;
    d_pin    = '0;
    rd_val   = '0;
    for (int ch = 0; ch < NPINS; ch++) begin
      s_pin[ch] = pin_match(s, ch) && !i0;
      d_pin[ch] = pin_match(d, ch);
      if (pin_match(s, ch)) rd_val = pin_in[ch*WIDTH +: WIDTH];
    end
    if (s_is_reg) rd_val = rf_rd_data;
    else if (s == PC_ADDR) rd_val = pc_q + WIDTH'(1);
    src_val = i0 ? {{(WIDTH-7){1'b0}}, s} : rd_val;
    // i1 with a register-to-itself move is the clear idiom.
    wr_val  = (!i0 && i1 && (s == d)) ? '0 : src_val;
    stall   = (|(s_pin & ~pin_in_valid)) ||
              (|(d_pin & pin_out_valid_q & ~pin_out_ready));
    exec    = (state_q == ST_RUN) && !stall;
  end

  // Control FSM and next pc. A stalled instruction is held and re-executed
  // from RUN one cycle after its blocking condition clears.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_RUN: begin
        if (stall) begin
          state_d = ST_STALL;
        end else begin
          pc_d = pc_q + WIDTH'(1);
          if (d == PC_ADDR) pc_d = wr_val;
`ifdef MOVE_CORE_SKIP_EN
          else if (skip_taken(d, wr_val == '0)) pc_d = pc_q + WIDTH'(2);
`endif
          if (d == HALT_ADDR) state_d = ST_HALT;
        end
      end
      ST_STALL: if (!stall) state_d = ST_RUN;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RUN;
    endcase
  end

  // Output channels keep draining in every state; a new write wins over
  // the acceptance of the old word so back-to-back writes never stall.
  always_comb begin
    pin_out_d       = pin_out_q;
    pin_out_valid_d = pin_out_valid_q;
    for (int ch = 0; ch < NPINS; ch++) begin
      if (exec && d_pin[ch]) begin
        pin_out_d[ch*WIDTH +: WIDTH] = wr_val;
        pin_out_valid_d[ch]          = 1'b1;
      end else if (pin_out_valid_q[ch] && pin_out_ready[ch]) begin
        pin_out_valid_d[ch] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_RUN;
      pc_q            <= '0;
      pin_out_q       <= '0;
      pin_out_valid_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      pin_out_q       <= pin_out_d;
      pin_out_valid_q <= pin_out_valid_d;
    end
  end

  move_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (s[4:0]),
    .rd_data (rf_rd_data),
    .wr_en   (exec && d_is_reg),
    .wr_addr (d[4:0]),
    .wr_data (wr_val)
  );

  // rst gates ready directly so nothing is consumed while reset is held.
  assign pin_in_ready  = (exec && !rst) ? s_pin : '0;
  assign pc            = pc_q;
  assign pin_out       = pin_out_q;
  assign pin_out_valid = pin_out_valid_q;
  assign halted        = (state_q == ST_HALT);

endmodule

// File: tb/tb_move_core.sv
// tb_move_core: directed self-checking bench for move_core. A default
// instance (WIDTH=16) runs the main program; a WIDTH=8 instance checks
// the pc wrap. Expected values are hand-computed constants.
module tb_move_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [15:0] pc;
  logic [15:0] instruction;
  logic [63:0] pin_in;
  logic [3:0]  pin_in_valid;
  logic [3:0]  pin_in_ready;
  logic [63:0] pin_out;
  logic [3:0]  pin_out_valid;
  logic [3:0]  pin_out_ready;
  logic        halted;

  logic [7:0]  pc8;
  logic [15:0] instruction8;
  logic [31:0] pin_in8;
  logic [3:0]  pin_in_valid8;
  logic [3:0]  pin_in_ready8;
  logic [31:0] pin_out8;
  logic [3:0]  pin_out_valid8;
  logic [3:0]  pin_out_ready8;
  logic        halted8;

  int total = 0;
  int bad   = 0;
  int rdy1_cnt = 0;
  int rdy1_base;
  int exp_skip;

  // Free-running clock, posedges at 5, 15, 25 ...
  always #5 clk = ~clk;

  move_core dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .instruction   (instruction),
    .pin_in        (pin_in),
    .pin_in_valid  (pin_in_valid),
    .pin_in_ready  (pin_in_ready),
    .pin_out       (pin_out),
    .pin_out_valid (pin_out_valid),
    .pin_out_ready (pin_out_ready),
    .halted        (halted)
  );

  move_core #(.WIDTH(8)) dut8 (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc8),
    .instruction   (instruction8),
    .pin_in        (pin_in8),
    .pin_in_valid  (pin_in_valid8),
    .pin_in_ready  (pin_in_ready8),
    .pin_out       (pin_out8),
    .pin_out_valid (pin_out_valid8),
    .pin_out_ready (pin_out_ready8),
    .halted        (halted8)
  );

  // Counts edges on which channel 1 input is consumed.
  always @(posedge clk) begin
    if (pin_in_ready[1]) rdy1_cnt <= rdy1_cnt + 1;
  end

  function automatic logic [15:0] mk(input logic i1, input logic [6:0] d,
                                     input logic i0, input logic [6:0] s);
    return {i1, d, i0, s};
  endfunction

  localparam logic [15:0] NOP = 16'h3080;

  task automatic applyStimulus(input logic [15:0] instr);
    instruction = instr;
    #1;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Main directed program; pc values in comments are the pc after each edge.
  initial begin
`ifdef MOVE_CORE_SKIP_EN
    exp_skip = 6;
`else
    exp_skip = 5;
`endif
    instruction    = mk(1'b0, 7'h01, 1'b0, 7'h40);
    pin_in         = '0;
    pin_in_valid   = 4'b0001;
    pin_out_ready  = 4'b0000;
    instruction8   = NOP;
    pin_in8        = '0;
    pin_in_valid8  = '0;
    pin_out_ready8 = '0;

    $display("[TB] reset");
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_pc", 32'(pc), 32'h0);
    checkOutput("rst_halted", 32'(halted), 32'h0);
    checkOutput("rst_out_valid", 32'(pin_out_valid), 32'h0);
    checkOutput("rst_in_ready", 32'(pin_in_ready), 32'h0);
    checkOutput("rst_pc8", 32'(pc8), 32'h0);
    stepCycle();
    rst = 1'b0;
    pin_in_valid = '0;

    $display("[TB] immediate to reg3, reg3 to pin0");
    applyStimulus(mk(1'b0, 7'h03, 1'b1, 7'h2A));
    stepCycle();
    pin_out_ready = 4'b0001;
    applyStimulus(mk(1'b0, 7'h40, 1'b0, 7'h03));
    stepCycle();
    checkOutput("pin0_data", 32'(pin_out[15:0]), 32'h2A);
    checkOutput("pin0_valid", 32'(pin_out_valid[0]), 32'h1);
    checkOutput("pc_after_two", 32'(pc), 32'h2);
    applyStimulus(NOP);
    stepCycle();
    checkOutput("pin0_drained", 32'(pin_out_valid[0]), 32'h0);

    $display("[TB] pin1 read stall");
    rdy1_base = rdy1_cnt;
    applyStimulus(mk(1'b0, 7'h07, 1'b0, 7'h41));
    checkOutput("in1_ready_low", 32'(pin_in_ready[1]), 32'h0);
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      checkOutput("stall_pc_held", 32'(pc), 32'h3);
    end
    pin_in[31:16]   = 16'h1234;
    pin_in_valid[1] = 1'b1;
    #1;
    stepCycle();
    checkOutput("stall_release_pc", 32'(pc), 32'h3);
    checkOutput("in1_ready_run", 32'(pin_in_ready[1]), 32'h1);
    stepCycle();
    checkOutput("stall_exec_pc", 32'(pc), 32'h4);
    pin_in_valid[1] = 1'b0;
    checkOutput("in1_ready_pulses", 32'(rdy1_cnt - rdy1_base), 32'h1);
    pin_out_ready[3] = 1'b1;
    applyStimulus(mk(1'b0, 7'h43, 1'b0, 7'h07));
    stepCycle();
    checkOutput("reg7_value", 32'(pin_out[63:48]), 32'h1234);

    $display("[TB] pin2 write backpressure");
    applyStimulus(mk(1'b0, 7'h42, 1'b1, 7'h11));
    stepCycle();
    checkOutput("pin2_first", 32'(pin_out[47:32]), 32'h11);
    checkOutput("pin2_first_pc", 32'(pc), 32'h6);
    applyStimulus(mk(1'b0, 7'h42, 1'b1, 7'h22));
    stepCycle();
    checkOutput("pin2_stall_pc", 32'(pc), 32'h6);
    checkOutput("pin2_stall_data", 32'(pin_out[47:32]), 32'h11);
    stepCycle();
    checkOutput("pin2_stall_pc2", 32'(pc), 32'h6);
    pin_out_ready[2] = 1'b1;
    #1;
    stepCycle();
    checkOutput("pin2_accept_pc", 32'(pc), 32'h6);
    checkOutput("pin2_accept_valid", 32'(pin_out_valid[2]), 32'h0);
    stepCycle();
    checkOutput("pin2_second_pc", 32'(pc), 32'h7);
    checkOutput("pin2_second", 32'(pin_out[47:32]), 32'h22);
    checkOutput("pin2_second_valid", 32'(pin_out_valid[2]), 32'h1);
    applyStimulus(mk(1'b0, 7'h42, 1'b1, 7'h33));
    stepCycle();
    checkOutput("pin2_reload_pc", 32'(pc), 32'h8);
    checkOutput("pin2_reload", 32'(pin_out[47:32]), 32'h33);
    applyStimulus(NOP);
    stepCycle();
    checkOutput("pin2_drained", 32'(pin_out_valid[2]), 32'h0);

    $display("[TB] clear idiom");
    pin_in[15:0]    = 16'h00FF;
    pin_in_valid[0] = 1'b1;
    applyStimulus(mk(1'b0, 7'h05, 1'b0, 7'h40));
    stepCycle();
    pin_in_valid[0] = 1'b0;
    applyStimulus(mk(1'b0, 7'h43, 1'b0, 7'h05));
    stepCycle();
    checkOutput("reg5_loaded", 32'(pin_out[63:48]), 32'hFF);
    applyStimulus(mk(1'b1, 7'h05, 1'b0, 7'h05));
    stepCycle();
    applyStimulus(mk(1'b0, 7'h43, 1'b0, 7'h05));
    stepCycle();
    checkOutput("reg5_cleared", 32'(pin_out[63:48]), 32'h0);
    checkOutput("clear_pc", 32'(pc), 32'hD);

    $display("[TB] pc write and read");
    applyStimulus(mk(1'b0, 7'h20, 1'b1, 7'h10));
    stepCycle();
    checkOutput("pc_jump", 32'(pc), 32'h10);
    applyStimulus(mk(1'b0, 7'h04, 1'b0, 7'h20));
    stepCycle();
    applyStimulus(mk(1'b0, 7'h43, 1'b0, 7'h04));
    stepCycle();
    checkOutput("pc_read_value", 32'(pin_out[63:48]), 32'h11);

    $display("[TB] skip port");
    applyStimulus(mk(1'b0, 7'h20, 1'b1, 7'h04));
    stepCycle();
    applyStimulus(mk(1'b0, 7'h21, 1'b0, 7'h00));
    stepCycle();
    checkOutput("skip_zero_pc", 32'(pc), 32'(exp_skip));
    applyStimulus(mk(1'b0, 7'h20, 1'b1, 7'h04));
    stepCycle();
    applyStimulus(mk(1'b0, 7'h21, 1'b1, 7'h05));
    stepCycle();
    checkOutput("skip_nonzero_pc", 32'(pc), 32'h5);

    $display("[TB] halt");
    applyStimulus(mk(1'b0, 7'h41, 1'b1, 7'h07));
    stepCycle();
    checkOutput("pin1_pending", 32'(pin_out_valid[1]), 32'h1);
    applyStimulus(mk(1'b0, 7'h22, 1'b1, 7'h01));
    stepCycle();
    checkOutput("halted_set", 32'(halted), 32'h1);
    checkOutput("halt_pc", 32'(pc), 32'h7);
    pin_out_ready[1] = 1'b1;
    pin_in[15:0]     = 16'h0055;
    pin_in_valid[0]  = 1'b1;
    applyStimulus(mk(1'b0, 7'h20, 1'b0, 7'h40));
    checkOutput("halt_in_ready", 32'(pin_in_ready), 32'h0);
    for (int k = 0; k < 10; k++) begin
      stepCycle();
      checkOutput("halt_pc_frozen", 32'(pc), 32'h7);
    end
    checkOutput("halt_drain", 32'(pin_out_valid[1]), 32'h0);
    checkOutput("halt_still", 32'(halted), 32'h1);

    $display("[TB] reset out of halt and mid-stall");
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_halt_pc", 32'(pc), 32'h0);
    checkOutput("rst_halt_flag", 32'(halted), 32'h0);
    stepCycle();
    rst = 1'b0;
    pin_in_valid = '0;
    applyStimulus(NOP);
    for (int k = 0; k < 3; k++) stepCycle();
    checkOutput("nop_pc", 32'(pc), 32'h3);
    applyStimulus(mk(1'b0, 7'h08, 1'b0, 7'h42));
    stepCycle();
    stepCycle();
    checkOutput("stall2_pc", 32'(pc), 32'h3);
    pin_in_valid[2] = 1'b1;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_stall_pc", 32'(pc), 32'h0);
    checkOutput("rst_in_ready", 32'(pin_in_ready), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(NOP);
    stepCycle();
    checkOutput("after_rst_run", 32'(pc), 32'h1);

    $display("[TB] WIDTH=8 pc wrap");
    pin_in8[7:0]     = 8'hFF;
    pin_in_valid8[0] = 1'b1;
    instruction8     = mk(1'b0, 7'h20, 1'b0, 7'h40);
    #1;
    stepCycle();
    checkOutput("pc8_ff", 32'(pc8), 32'hFF);
    instruction8 = NOP;
    stepCycle();
    checkOutput("pc8_wrap", 32'(pc8), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/move_core.md
MOVE_CORE -- requirements
Module: move_core

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning datapath, register and PC width in bits (8..32).
REQ-002 SHALL have parameter NREGS, default 32, meaning number of data registers (1..32).
REQ-003 SHALL have parameter NPINS, default 4, meaning number of pin I/O channels (1..16).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port pc  output  WIDTH  current instruction address.
REQ-007 SHALL have port instruction  input  16  instruction at pc, valid combinationally in the same cycle.
REQ-008 SHALL have port pin_in / pin_in_valid / pin_in_ready  input / input / output  NPINS*WIDTH / NPINS / NPINS  per-channel input streams.
REQ-009 SHALL have port pin_out / pin_out_valid / pin_out_ready  output / output / input  NPINS*WIDTH / NPINS / NPINS  per-channel output streams.
REQ-010 SHALL have port halted  output  1  high while in HALT.

Function
REQ-011 SHALL decode fields: S=instruction[6:0], i0=instruction[7], D=instruction[14:8], i1=instruction[15].
REQ-012 SHALL use address map for S and D: 0x00..NREGS-1 data regs; 0x20 PC; 0x21 SKIP (write-only); 0x22 HALT (write-only); 0x40+ch pin channel ch for ch<NPINS. All other addresses: read 0, write ignored.
REQ-013 SHALL read PC address as pc+1, modulo 2^WIDTH.
REQ-014 SHALL use source value = S zero-extended when i0=1, else the value read from address S.
REQ-015 SHALL force the write value to 0 when i0=0, i1=1 and S==D (clear); i1 has no other effect.
REQ-016 SHALL execute one instruction per cycle in RUN, with no stall. A data-register read returns the pre-write value when the same register is written that cycle.
REQ-017 SHALL update next pc as: written value if D=0x20; otherwise pc+1. Wrap modulo 2^WIDTH.
REQ-018 SHALL stall when reading pin channel ch with pin_in_valid[ch]=0. During a stall: pc held, no register, pin or flag update.
REQ-019 SHALL stall when writing pin channel ch with pin_out_valid[ch]=1 and pin_out_ready[ch]=0.
REQ-020 SHALL drive pin_in_ready[ch]=1 only when all hold: state RUN, S selects ch with i0=0, and no stall per REQ-018/019. This consumes the word on that edge.
REQ-021 SHALL, on pin write to ch: load pin_out[ch] and set pin_out_valid[ch]. Simultaneous acceptance of the old word (ready=1) with a new write SHALL reload without a stall.
REQ-022 SHALL clear pin_out_valid[ch] on the edge where valid=1, ready=1 and no new write to ch occurs.
REQ-023 SHALL use FSM states RUN, STALL, HALT. RUN->STALL on a REQ-018/019 condition. STALL->RUN on the edge where the condition clears, then execute the held instruction. RUN->HALT on a non-stalled write to 0x22. HALT is left only by reset.
REQ-024 SHALL, in HALT: freeze pc, ignore instructions, hold pin_in_ready=0, and continue draining pin_out handshakes.

Reset
REQ-025 SHALL, on rst asserted, immediately set: pc=0, all data regs=0, pin_out=0, pin_out_valid=0, skip flag=0, state RUN, halted=0.
REQ-026 SHALL abandon any in-progress stall on reset; pin_in_ready SHALL be 0 while rst=1.

Configuration
REQ-027 SHALL support macro MOVE_CORE_SKIP_EN. When defined, a non-stalled write of value 0 to 0x21 sets next pc to pc+2; a non-zero write to 0x21 has no effect. When undefined, 0x21 behaves as unmapped.

Structure
REQ-028 SHALL place in shared package move_pkg: address constants (REG_BASE, PC_ADDR, SKIP_ADDR, HALT_ADDR, PIN_BASE), field bit positions, and the state enum.
REQ-029 SHALL implement data registers in sub-module move_regfile: NREGS x WIDTH, one async read port, one sync write port, async reset.

Verification
REQ-030 SHALL cover: reset, then 0x2A immediate -> reg3, reg3 -> pin0 with ready=1 -> pin_out[0]=0x2A for one cycle, pc=2.
REQ-031 SHALL cover: read pin1 with valid low for 3 cycles, then valid=1 data 0x1234 -> pc held 3 cycles, in_ready pulses once, dest reg=0x1234.
REQ-032 SHALL cover: two pin2 writes with out_ready=0 -> second write stalls; raising ready releases it, with the second value presented after.
REQ-033 SHALL cover: S=D=5, i0=0, i1=1 on reg5=0xFF -> reg5=0. Immediate 0x10 -> PC -> next pc=0x10. With WIDTH=8 at pc=0xFF -> pc wraps to 0.
REQ-034 SHALL cover: with MOVE_CORE_SKIP_EN, reg0=0 -> 0x21 at pc=4 -> next pc=6, and a non-zero value -> pc=5. Without the macro, pc=5 in both cases.
REQ-035 SHALL cover: write 0x22 -> halted=1, pc frozen over 10 cycles; rst asserted mid-stall -> pc=0, state RUN.
